// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port line arbiter and beat sequencer for the C2/A2/D2 memory bus
// Optional feature: define ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles (err = 1).
module mem_bus_arbiter #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 16,
   parameter int LINE_BITS = 128,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   RESET,
   input  logic [1:0]             req_valid_i,
   input  logic [1:0]             req_write_i,
   input  logic [2*ADDR_W-1:0]    req_addr_i,
   input  logic [2*LINE_BITS-1:0] req_wline_i,
   output logic [1:0]             gnt_o,
   output logic [1:0]             done_o,
   output logic                   err_o,
   output logic [LINE_BITS-1:0]   rline_o,
   output logic                   busy_o,
   output logic [1:0]             mem_cmd_o,
   output logic [ADDR_W-1:0]      mem_addr_o,
   output logic [DATA_W-1:0]      mem_wdata_o,
   input  logic [1:0]             mem_c2_in_i,
   input  logic [DATA_W-1:0]      mem_rdata_i
);

   localparam int BEATS = LINE_BITS / DATA_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_WBURST = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_RBURST = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;
   localparam logic [1:0] C2_RESP   = 2'd1;

   logic [2:0]           state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 write_q, write_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [LINE_BITS-1:0] line_q, line_d;
   logic [LINE_BITS-1:0] rline_q, rline_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 last_grant_q, last_grant_d;
   logic [1:0]           gnt_q, gnt_d;
   logic                 win;
   logic                 resp;

`ifdef ARB_TIMEOUT_EN
   logic [7:0]           tmo_q, tmo_d;
   logic                 err_q, err_d;
`endif

   assign resp = (mem_c2_in_i == C2_RESP);

   // Next-state logic: arbitration in IDLE, beat sequencing, response wait.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      write_d      = write_q;
      addr_d       = addr_q;
      line_d       = line_q;
      rline_d      = rline_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      gnt_d        = 2'b00;
      win          = 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_d        = tmo_q;
      err_d        = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid_i != 2'b00) begin
               // On a tie the requester that did not win last time goes first.
               win          = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
               owner_d      = win;
               write_d      = req_write_i[win];
               addr_d       = win ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
               line_d       = win ? req_wline_i[2*LINE_BITS-1:LINE_BITS] : req_wline_i[LINE_BITS-1:0];
               rline_d      = '0;
               cnt_d        = '0;
               gnt_d        = win ? 2'b10 : 2'b01;
               last_grant_d = win;
               state_d      = S_CMD;
`ifdef ARB_TIMEOUT_EN
               err_d        = 1'b0;
`endif
            end
         end
         S_CMD: begin
            // Beat 0 of a write goes out with the command itself.
`ifdef ARB_TIMEOUT_EN
            tmo_d = 8'd0;
`endif
            if (write_q) begin
               cnt_d   = CNT_W'(1);
               state_d = S_WBURST;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WBURST: begin
            if (cnt_q == LAST_BEAT) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (resp) begin
               if (write_q) begin
                  state_d = S_DONE;
               end else begin
                  rline_d[int'(cnt_q)*DATA_W +: DATA_W] = mem_rdata_i;
                  cnt_d   = CNT_W'(1);
                  state_d = S_RBURST;
               end
`ifdef ARB_TIMEOUT_EN
            end else if (tmo_q == 8'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + 8'd1;
`endif
            end
         end
         S_RBURST: begin
            rline_d[int'(cnt_q)*DATA_W +: DATA_W] = mem_rdata_i;
            if (cnt_q == LAST_BEAT) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; RESET aborts any transaction at once.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         line_q       <= '0;
         rline_q      <= '0;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         gnt_q        <= 2'b00;
`ifdef ARB_TIMEOUT_EN
         tmo_q        <= 8'd0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         line_q       <= line_d;
         rline_q      <= rline_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
`ifdef ARB_TIMEOUT_EN
         tmo_q        <= tmo_d;
         err_q        <= err_d;
`endif
      end
   end

   // Outputs decode registered state only, so they follow RESET asynchronously.
   always_comb begin
      gnt_o       = gnt_q;
      busy_o      = (state_q != S_IDLE);
      done_o      = (state_q == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      mem_cmd_o   = (state_q == S_CMD) ? (write_q ? CMD_WRITE : CMD_READ) : CMD_NOP;
      mem_addr_o  = addr_q;
      mem_wdata_o = '0;
      if (state_q == S_CMD || state_q == S_WBURST) begin
         mem_wdata_o = line_q[int'(cnt_q)*DATA_W +: DATA_W];
      end
      rline_o     = rline_q;
`ifdef ARB_TIMEOUT_EN
      err_o       = (state_q == S_DONE) && err_q;
`else
      err_o       = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - table-driven scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   localparam int AW = 14;
   localparam int DW = 16;
   localparam int LB = 128;
`ifdef ARB_TIMEOUT_EN
   localparam int TB_TMO = 5;
`else
   localparam int TB_TMO = 255;
`endif

   logic            clk = 1'b0;
   logic            RESET;
   logic [1:0]      req_valid, req_write;
   logic [2*AW-1:0] req_addr;
   logic [2*LB-1:0] req_wline;
   logic [1:0]      gnt, done;
   logic            err, busy;
   logic [LB-1:0]   rline;
   logic [1:0]      mem_cmd;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [1:0]      mem_c2;
   logic [DW-1:0]   mem_rdata;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_BITS(LB), .TIMEOUT(TB_TMO)) dut (
      .clk(clk), .RESET(RESET),
      .req_valid_i(req_valid), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wline_i(req_wline),
      .gnt_o(gnt), .done_o(done), .err_o(err), .rline_o(rline), .busy_o(busy),
      .mem_cmd_o(mem_cmd), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_c2_in_i(mem_c2), .mem_rdata_i(mem_rdata)
   );

   typedef struct {
      logic [1:0]   valid;
      logic         owner;
      logic [1:0]   write;
      logic [13:0]  addr0;
      logic [13:0]  addr1;
      logic [127:0] line0;
      logic [127:0] line1;
      logic [15:0]  rbase;
      int           lat;
      int           stray;
      int           drop;
      bit           tmo;
   } row_t;

   typedef struct {
      logic [1:0]   mask;
      logic [127:0] rline;
      bit           chk_rline;
      logic         err;
      int           cycle;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   row_t rows[5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction: cycle 0 is the IDLE cycle in which the request is presented.
   task automatic run_row(input row_t r);
      exp_t         e;
      exp_t         got;
      logic [127:0] line;
      logic [13:0]  addr;
      logic         wr;
      int           rc;
      bit           seen;
      tick();
      chk("idle_busy", busy, 1'b0);
      req_valid = r.valid;
      req_write = r.write;
      req_addr  = {r.addr1, r.addr0};
      req_wline = {r.line1, r.line0};
      wr   = r.write[r.owner];
      addr = r.owner ? r.addr1 : r.addr0;
      line = r.owner ? r.line1 : r.line0;
      rc   = wr ? 9 + r.lat : 2 + r.lat;
      e.mask      = r.owner ? 2'b10 : 2'b01;
      e.err       = r.tmo;
      e.chk_rline = !wr;
      e.rline     = '0;
      if (!wr && !r.tmo) begin
         for (int i = 0; i < 8; i++) e.rline[i*16 +: 16] = r.rbase + 16'(i);
      end
      e.cycle = r.tmo ? 3 + TB_TMO : 10 + r.lat;
      sb.push_back(e);
      seen = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         tick();
         if (c == 1) begin
            chk("gnt", gnt, e.mask);
            chk("cmd", mem_cmd, wr ? 2'd3 : 2'd2);
            chk("addr", mem_addr, addr);
            chk("busy", busy, 1'b1);
            req_valid[r.owner] = 1'b0;
         end
         if (c == 2) begin
            chk("gnt_pulse", gnt, 2'b00);
            chk("cmd_nop", mem_cmd, 2'd0);
         end
         if (wr && c <= 8) chk($sformatf("wdata%0d", c - 1), mem_wdata, line[(c-1)*16 +: 16]);
         if (c == r.drop) req_valid[~r.owner] = 1'b0;
         mem_c2    = {1'b0, ((!r.tmo && c == rc) || c == r.stray)};
         mem_rdata = (!wr && !r.tmo && c >= rc && c < rc + 8) ? r.rbase + 16'(c - rc) : 16'hDEAD;
         if (done != 2'b00) begin
            seen = 1;
            got = sb.pop_front();
            chk("done", done, got.mask);
            chk("done_cycle", c, got.cycle);
            chk("err", err, got.err);
            if (got.chk_rline) chk("rline", rline, got.rline);
         end
      end
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: got no done expected done=%0h", e.mask);
         void'(sb.pop_front());
      end
      mem_c2 = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1);
   end

   initial begin
      RESET = 1'b0; req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wline = '0;
      mem_c2 = 2'b00; mem_rdata = '0;
      rows[0] = '{2'b11, 1'b0, 2'b10, 14'h0123, 14'h3FFF, 128'h0,
                  128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000, 3, 0, 0, 1'b0};
      rows[1] = '{2'b11, 1'b1, 2'b10, 14'h0123, 14'h3FFF, 128'h0,
                  128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000, 0, 4, 0, 1'b0};
      rows[2] = '{2'b01, 1'b0, 2'b01, 14'h0001, 14'h0000,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h0, 16'h0000, 2, 8, 0, 1'b0};
      rows[3] = '{2'b10, 1'b1, 2'b00, 14'h0000, 14'h2AAA, 128'h0, 128'h0, 16'hA000, 0, 5, 0, 1'b0};
      rows[4] = '{2'b11, 1'b0, 2'b00, 14'h1555, 14'h0777, 128'h0, 128'h0, 16'h5A00, 1, 1, 3, 1'b0};

      #2 RESET = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_done", done, 2'b00);
      chk("rst_err", err, 1'b0);
      chk("rst_cmd", mem_cmd, 2'd0);
      chk("rst_addr", mem_addr, 14'h0);
      chk("rst_wdata", mem_wdata, 16'h0);
      chk("rst_rline", rline, 128'h0);
      tick(); tick();
      RESET = 1'b0;

      // Reset in the fourth RBURST cycle of a read.
      tick();
      req_valid = 2'b01; req_write = 2'b00; req_addr = {14'h0, 14'h0555};
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) req_valid = 2'b00;
         mem_c2    = {1'b0, c == 2};
         mem_rdata = (c >= 2) ? 16'h0100 + 16'(c - 2) : 16'hDEAD;
      end
      chk("mid_busy", busy, 1'b1);
      RESET = 1'b1;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_cmd", mem_cmd, 2'd0);
      chk("arst_addr", mem_addr, 14'h0);
      chk("arst_rline", rline, 128'h0);
      chk("arst_done", done, 2'b00);
      tick();
      chk("arst_hold_done", done, 2'b00);
      mem_c2 = 2'b00;
      tick();
      RESET = 1'b0;

      foreach (rows[i]) run_row(rows[i]);

      // Withdrawn request from the last row must not be granted.
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("withdraw_gnt", gnt, 2'b00);
         chk("withdraw_busy", busy, 1'b0);
      end

`ifdef ARB_TIMEOUT_EN
      run_row('{2'b01, 1'b0, 2'b00, 14'h0042, 14'h0000, 128'h0, 128'h0, 16'h0000, 0, 0, 0, 1'b1});
`endif

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
